// File: rtl/ncpu32k_dcache_line_seq_if.sv
// Signal bundle between the dcache line sequencer, its controller, RAM port B
// and the memory-side writeback/refill channels.
interface ncpu32k_dcache_line_seq_if #(
  parameter int unsigned AW    = 9,
  parameter int unsigned DW    = 32,
  parameter int unsigned CL_P2 = 3
);
  logic                  req_valid;
  logic                  req_ready;
  logic [AW-CL_P2-1:0]   req_idx;
  logic                  req_dirty;
  logic                  req_fill;
  logic                  busy;
  logic                  done;
  logic                  ram_en_b;
  logic [DW/8-1:0]       ram_we_b;
  logic [AW-1:0]         ram_addr_b;
  logic [DW-1:0]         ram_din_b;
  logic [DW-1:0]         ram_dout_b;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [DW-1:0]         wb_data;
  logic                  wb_last;
  logic                  rf_valid;
  logic                  rf_ready;
  logic [DW-1:0]         rf_data;

  // Sequencer side
  modport master (
    input  req_valid, req_idx, req_dirty, req_fill, ram_dout_b, wb_ready, rf_valid, rf_data,
    output req_ready, busy, done, ram_en_b, ram_we_b, ram_addr_b, ram_din_b,
           wb_valid, wb_data, wb_last, rf_ready
  );

  // Controller / RAM / memory side
  modport slave (
    output req_valid, req_idx, req_dirty, req_fill, ram_dout_b, wb_ready, rf_valid, rf_data,
    input  req_ready, busy, done, ram_en_b, ram_we_b, ram_addr_b, ram_din_b,
           wb_valid, wb_data, wb_last, rf_ready
  );
endinterface

// File: rtl/ncpu32k_dcache_line_seq.sv
// Dcache line-transfer sequencer: owns RAM port B, writes back a dirty victim
// line to memory, then optionally refills the same line from memory.
module ncpu32k_dcache_line_seq #(
  parameter int unsigned AW    = 9,
  parameter int unsigned DW    = 32,
  parameter int unsigned CL_P2 = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  ncpu32k_dcache_line_seq_if.master  bus
);

  localparam int unsigned IW = AW - CL_P2;
  localparam int unsigned BW = DW / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_RD   = 3'd1,
    WB_LD   = 3'd2,
    WB_SEND = 3'd3,
    FILL    = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CL_P2-1:0] cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             fill_q, fill_d;
  logic [DW-1:0]    wb_data_q, wb_data_d;
  logic             last;

  logic             req_ready;
  logic             done;
  logic             ram_en;
  logic [BW-1:0]    ram_we;
  logic [AW-1:0]    ram_addr;
  logic [DW-1:0]    ram_din;
  logic             wb_valid;
  logic             wb_last;
  logic             rf_ready;

  assign last = (cnt_q == {CL_P2{1'b1}});

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      fill_q    <= 1'b0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      fill_q    <= fill_d;
      wb_data_q <= wb_data_d;
    end
  end

  // Next-state and output decode; outputs forced idle while reset is held
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    fill_d    = fill_q;
    wb_data_d = wb_data_q;
    req_ready = 1'b0;
    done      = 1'b0;
    ram_en    = 1'b0;
    ram_we    = '0;
    ram_addr  = '0;
    ram_din   = '0;
    wb_valid  = 1'b0;
    wb_last   = 1'b0;
    rf_ready  = 1'b0;

    if (!rst_n) begin
      req_ready = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          req_ready = 1'b1;
          if (bus.req_valid) begin
            idx_d  = bus.req_idx;
            fill_d = bus.req_fill;
            cnt_d  = '0;
            if (bus.req_dirty)     state_d = WB_RD;
            else if (bus.req_fill) state_d = FILL;
            else                   state_d = DONE;
          end
        end
        WB_RD: begin
          ram_en   = 1'b1;
          ram_addr = {idx_q, cnt_q};
          state_d  = WB_LD;
        end
        WB_LD: begin
          wb_data_d = bus.ram_dout_b;
          state_d   = WB_SEND;
        end
        WB_SEND: begin
          wb_valid = 1'b1;
          wb_last  = last;
          if (bus.wb_ready) begin
            cnt_d = cnt_q + CL_P2'(1);
            if (!last)       state_d = WB_RD;
            else if (fill_q) state_d = FILL;
            else             state_d = DONE;
          end
        end
        FILL: begin
          rf_ready = 1'b1;
          if (bus.rf_valid) begin
            ram_en   = 1'b1;
            ram_we   = '1;
            ram_addr = {idx_q, cnt_q};
            ram_din  = bus.rf_data;
            cnt_d    = cnt_q + CL_P2'(1);
            if (last) state_d = DONE;
          end
        end
        DONE: begin
          done    = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.busy       = ~req_ready;
  assign bus.done       = done;
  assign bus.ram_en_b   = ram_en;
  assign bus.ram_we_b   = ram_we;
  assign bus.ram_addr_b = ram_addr;
  assign bus.ram_din_b  = ram_din;
  assign bus.wb_valid   = wb_valid;
  assign bus.wb_data    = wb_data_q;
  assign bus.wb_last    = wb_last;
  assign bus.rf_ready   = rf_ready;

endmodule

// File: tb/tb_ncpu32k_dcache_line_seq.sv
// Directed bench for the dcache line sequencer with a port-B RAM model.
module tb_ncpu32k_dcache_line_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [31:0] mem [0:511];
  logic        pl_en;
  logic [8:0]  pl_addr;
  logic [31:0] pl_data;

  ncpu32k_dcache_line_seq_if #(.AW(9), .DW(32), .CL_P2(3)) bus ();

  ncpu32k_dcache_line_seq #(.AW(9), .DW(32), .CL_P2(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first byte-write RAM port B plus a bench preload path
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (bus.ram_en_b) begin
      bus.ram_dout_b <= mem[bus.ram_addr_b];
      for (int b = 0; b < 4; b++)
        if (bus.ram_we_b[b]) mem[bus.ram_addr_b][b*8 +: 8] <= bus.ram_din_b[b*8 +: 8];
    end
  end

  task automatic preload(input int base, input int n, input logic [31:0] first);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pl_en   = 1'b1;
      pl_addr = 9'(base + i);
      pl_data = first + 32'(i);
    end
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic issue(input logic [5:0] idx, input logic dirty, input logic fill);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_idx   = idx;
    bus.req_dirty = dirty;
    bus.req_fill  = fill;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_idx   = 6'd7;
    bus.req_dirty = 1'b1;
    bus.req_fill  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.ram_en_b !== 1'b0 ||
          bus.wb_valid !== 1'b0 || bus.rf_ready !== 1'b0 || bus.done !== 1'b0 ||
          bus.ram_we_b !== 4'h0 || bus.ram_addr_b !== 9'h0) begin
        errors++;
        $display("FAIL reset_outputs cyc %0d got rdy=%b busy=%b en=%b wbv=%b rfr=%b done=%b want 1 0 0 0 0 0",
                 c, bus.req_ready, bus.busy, bus.ram_en_b, bus.wb_valid, bus.rf_ready, bus.done);
      end
    end
    checks++;
    if (bus.wb_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_wb_data got %h want 0", bus.wb_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle got rdy=%b busy=%b want 1 0", bus.req_ready, bus.busy);
    end
  endtask

  task automatic test_fill_only;
    issue(6'd5, 1'b0, 1'b1);
    bus.rf_valid = 1'b1;
    bus.rf_data  = 32'h100;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.ram_en_b !== 1'b0) begin
      errors++;
      $display("FAIL fill_accept got rdy=%b en=%b want 1 0", bus.req_ready, bus.ram_en_b);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.rf_valid  = 1'b1;
      bus.rf_data   = 32'h100 + 32'(i);
      #1;
      checks++;
      if (bus.rf_ready !== 1'b1 || bus.ram_en_b !== 1'b1 || bus.ram_we_b !== 4'hF ||
          bus.ram_addr_b !== 9'(40 + i) || bus.ram_din_b !== 32'h100 + 32'(i) || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL fill_beat %0d got rfr=%b en=%b we=%h addr=%0d din=%h want 1 1 f %0d %h",
                 i, bus.rf_ready, bus.ram_en_b, bus.ram_we_b, bus.ram_addr_b, bus.ram_din_b,
                 40 + i, 32'h100 + 32'(i));
      end
    end
    @(negedge clk);
    bus.rf_valid = 1'b0;
    #1;
    checks++;
    if (bus.done !== 1'b1 || bus.ram_en_b !== 1'b0 || bus.rf_ready !== 1'b0 || bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_done got done=%b en=%b rfr=%b rdy=%b want 1 0 0 0",
               bus.done, bus.ram_en_b, bus.rf_ready, bus.req_ready);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.done !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL fill_done_pulse got done=%b rdy=%b want 0 1", bus.done, bus.req_ready);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mem[40 + i] !== 32'h100 + 32'(i)) begin
        errors++;
        $display("FAIL fill_mem word %0d got %h want %h", 40 + i, mem[40 + i], 32'h100 + 32'(i));
      end
    end
  endtask

  task automatic test_wb_only;
    int k = 0;
    int last_cyc = 0;
    bit seen_done = 0;
    preload(8, 8, 32'hA0);
    bus.wb_ready = 1'b1;
    issue(6'd1, 1'b1, 1'b0);
    for (int cyc = 1; cyc <= 60 && !seen_done; cyc++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      #1;
      if (bus.ram_we_b !== 4'h0 || bus.rf_ready !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL wb_only_no_write cyc %0d got we=%h rfr=%b want 0 0", cyc, bus.ram_we_b, bus.rf_ready);
      end
      if (bus.wb_valid === 1'b1) begin
        checks++;
        if (bus.wb_data !== 32'hA0 + 32'(k) || bus.wb_last !== (k == 7) ||
            cyc != (k == 0 ? 3 : last_cyc + 3)) begin
          errors++;
          $display("FAIL wb_beat %0d got data=%h last=%b cyc=%0d want %h %b %0d",
                   k, bus.wb_data, bus.wb_last, cyc, 32'hA0 + 32'(k), k == 7,
                   k == 0 ? 3 : last_cyc + 3);
        end
        last_cyc = cyc;
        k++;
      end
      if (bus.done === 1'b1) begin
        seen_done = 1;
        checks++;
        if (cyc != last_cyc + 1) begin
          errors++;
          $display("FAIL wb_done_cycle got %0d want %0d", cyc, last_cyc + 1);
        end
      end
    end
    checks++;
    if (!seen_done || k != 8) begin
      errors++;
      $display("FAIL wb_only_complete got done=%0d beats=%0d want 1 8", seen_done, k);
    end
  endtask

  task automatic test_wb_fill;
    int  k = 0;
    int  f = 0;
    bit  seen_done = 0;
    bit  held_valid = 0;
    logic [31:0] held_data = '0;
    preload(24, 8, 32'hB0);
    issue(6'd3, 1'b1, 1'b1);
    for (int cyc = 1; cyc <= 400 && !seen_done; cyc++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.wb_ready  = (cyc % 3 == 0);
      bus.rf_valid  = 1'($urandom_range(0, 1));
      bus.rf_data   = 32'hC0 + 32'(f);
      #1;
      if (bus.wb_valid === 1'b1) begin
        if (held_valid) begin
          checks++;
          if (bus.wb_data !== held_data) begin
            errors++;
            $display("FAIL wb_hold got %h want %h", bus.wb_data, held_data);
          end
        end
        if (bus.wb_ready) begin
          checks++;
          if (bus.wb_data !== 32'hB0 + 32'(k) || bus.wb_last !== (k == 7)) begin
            errors++;
            $display("FAIL wbf_beat %0d got data=%h last=%b want %h %b",
                     k, bus.wb_data, bus.wb_last, 32'hB0 + 32'(k), k == 7);
          end
          k++;
          held_valid = 0;
        end else begin
          held_valid = 1;
          held_data  = bus.wb_data;
        end
      end else begin
        held_valid = 0;
      end
      if (bus.ram_en_b === 1'b1 && bus.ram_we_b !== 4'h0) begin
        if (f == 0) begin
          checks++;
          if (k != 8) begin
            errors++;
            $display("FAIL wb_before_fill got beats=%0d want 8", k);
          end
        end
        checks++;
        if (bus.ram_addr_b !== 9'(24 + f) || bus.ram_din_b !== 32'hC0 + 32'(f) || bus.ram_we_b !== 4'hF) begin
          errors++;
          $display("FAIL wbf_write %0d got addr=%0d din=%h we=%h want %0d %h f",
                   f, bus.ram_addr_b, bus.ram_din_b, bus.ram_we_b, 24 + f, 32'hC0 + 32'(f));
        end
        f++;
      end
      if (bus.done === 1'b1) seen_done = 1;
    end
    bus.rf_valid = 1'b0;
    bus.wb_ready = 1'b0;
    checks++;
    if (!seen_done || k != 8 || f != 8) begin
      errors++;
      $display("FAIL wbf_complete got done=%0d beats=%0d writes=%0d want 1 8 8", seen_done, k, f);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mem[24 + i] !== 32'hC0 + 32'(i)) begin
        errors++;
        $display("FAIL wbf_mem word %0d got %h want %h", 24 + i, mem[24 + i], 32'hC0 + 32'(i));
      end
    end
  endtask

  task automatic test_noop;
    @(negedge clk);
    issue(6'd6, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL noop_accept got rdy=%b want 1", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.ram_en_b !== 1'b0 ||
        bus.wb_valid !== 1'b0 || bus.rf_ready !== 1'b0) begin
      errors++;
      $display("FAIL noop_done got done=%b busy=%b en=%b wbv=%b rfr=%b want 1 1 0 0 0",
               bus.done, bus.busy, bus.ram_en_b, bus.wb_valid, bus.rf_ready);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.done !== 1'b0 || bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL noop_idle got done=%b rdy=%b busy=%b want 0 1 0", bus.done, bus.req_ready, bus.busy);
    end
  endtask

  task automatic test_reset_mid_fill;
    preload(35, 1, 32'h55);
    issue(6'd4, 1'b0, 1'b1);
    bus.rf_valid = 1'b1;
    bus.rf_data  = 32'h200;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.rf_data   = 32'h200 + 32'(i);
      #1;
      checks++;
      if (bus.ram_en_b !== 1'b1 || bus.ram_addr_b !== 9'(32 + i)) begin
        errors++;
        $display("FAIL midfill_beat %0d got en=%b addr=%0d want 1 %0d", i, bus.ram_en_b, bus.ram_addr_b, 32 + i);
      end
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      rst_n        = 1'b0;
      bus.rf_data  = 32'h203;
      #1;
      checks++;
      if (bus.ram_en_b !== 1'b0 || bus.rf_ready !== 1'b0 || bus.req_ready !== 1'b1 ||
          bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL midfill_abort cyc %0d got en=%b rfr=%b rdy=%b busy=%b done=%b want 0 0 1 0 0",
                 c, bus.ram_en_b, bus.rf_ready, bus.req_ready, bus.busy, bus.done);
      end
    end
    @(negedge clk);
    rst_n        = 1'b1;
    bus.rf_valid = 1'b0;
    checks++;
    if (mem[34] !== 32'h202 || mem[35] !== 32'h55) begin
      errors++;
      $display("FAIL midfill_partial got w34=%h w35=%h want 202 55", mem[34], mem[35]);
    end
    issue(6'd2, 1'b0, 1'b1);
    bus.rf_valid = 1'b1;
    bus.rf_data  = 32'h300;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.rf_data   = 32'h300 + 32'(i);
      #1;
      checks++;
      if (bus.ram_en_b !== 1'b1 || bus.ram_addr_b !== 9'(16 + i) || bus.ram_din_b !== 32'h300 + 32'(i)) begin
        errors++;
        $display("FAIL refill2_beat %0d got en=%b addr=%0d din=%h want 1 %0d %h",
                 i, bus.ram_en_b, bus.ram_addr_b, bus.ram_din_b, 16 + i, 32'h300 + 32'(i));
      end
    end
    @(negedge clk);
    bus.rf_valid = 1'b0;
    #1;
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL refill2_done got %b want 1", bus.done);
    end
    @(negedge clk);
    checks++;
    if (mem[16] !== 32'h300 || mem[23] !== 32'h307) begin
      errors++;
      $display("FAIL refill2_mem got w16=%h w23=%h want 300 307", mem[16], mem[23]);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    pl_en         = 1'b0;
    pl_addr       = '0;
    pl_data       = '0;
    bus.wb_ready  = 1'b0;
    bus.rf_valid  = 1'b0;
    bus.rf_data   = '0;
    test_reset();
    test_fill_only();
    test_wb_only();
    test_wb_fill();
    test_noop();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
